// File: rtl/nmr_scan_sched.sv
// nmr_scan_sched: scan scheduler and SRAM port arbiter in front of NMR_bstrm.
// While idle the host owns the command SRAM. On GO the SRAM is handed to the
// bitstream generator, and N_SCAN repetitions of START / wait DONE / TR_DLY
// gap are run. Progress, completion and abort status are reported to the host.
module nmr_scan_sched #(
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DAT_WIDTH    = 128,
  parameter int SRAM_BYTEEN_WIDTH = 16,
  parameter int SCAN_WIDTH        = 16,
  parameter int TR_WIDTH          = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [SRAM_ADDR_WIDTH-1:0]   HOST_ADDR,
  input  logic                         HOST_WR,
  input  logic                         HOST_RD,
  input  logic [SRAM_DAT_WIDTH-1:0]    HOST_WR_DAT,
  input  logic [SRAM_BYTEEN_WIDTH-1:0] HOST_BYTEEN,
  output logic                         HOST_WAIT,
  output logic [SRAM_DAT_WIDTH-1:0]    HOST_RD_DAT,
  output logic                         HOST_RD_VALID,
  input  logic                         GO,
  input  logic                         ABORT,
  input  logic [SCAN_WIDTH-1:0]        N_SCAN,
  input  logic [TR_WIDTH-1:0]          TR_DLY,
  output logic                         BUSY,
  output logic [SCAN_WIDTH-1:0]        SCAN_CNT,
  output logic                         SCAN_DONE,
  output logic                         ALL_DONE,
  output logic                         ABORTED,
  output logic                         BS_START,
  input  logic                         BS_DONE,
  input  logic [SRAM_ADDR_WIDTH-1:0]   BS_SRAM_ADDR,
  input  logic                         BS_SRAM_CS,
  input  logic                         BS_SRAM_CLKEN,
  input  logic                         BS_SRAM_WR,
  input  logic [SRAM_DAT_WIDTH-1:0]    BS_SRAM_WR_DAT,
  input  logic [SRAM_BYTEEN_WIDTH-1:0] BS_SRAM_BYTEEN,
  output logic [SRAM_DAT_WIDTH-1:0]    BS_SRAM_RD_DAT,
  output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic                         SRAM_CS,
  output logic                         SRAM_CLKEN,
  output logic                         SRAM_WR,
  output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
  output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
  input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STRT = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [SCAN_WIDTH-1:0] SCAN_ZERO = {SCAN_WIDTH{1'b0}};
  localparam logic [SCAN_WIDTH-1:0] SCAN_ONE  = {{(SCAN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TR_WIDTH-1:0]   TR_ZERO   = {TR_WIDTH{1'b0}};
  localparam logic [TR_WIDTH-1:0]   TR_ONE    = {{(TR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r, next_state_s;
  logic [SCAN_WIDTH-1:0] n_scan_r, scan_cnt_r, scan_cnt_inc_s;
  logic [TR_WIDTH-1:0]   tr_dly_r, gap_cnt_r;
  logic                  abort_r, bs_done_prev_r, done_edge_s;
  logic                  busy_r, scan_done_r, all_done_r, aborted_r, bs_start_r, rd_valid_r;
  logic                  scan_done_s, all_done_s, aborted_s, host_req_s, host_wait_s;

  assign host_req_s     = HOST_WR | HOST_RD;
  assign done_edge_s    = BS_DONE & ~bs_done_prev_r;
  assign scan_cnt_inc_s = scan_cnt_r + SCAN_ONE;

  // SRAM ownership: host while idle, bitstream generator otherwise
  always_comb begin
    SRAM_ADDR   = HOST_ADDR;
    SRAM_CS     = host_req_s;
    SRAM_CLKEN  = host_req_s;
    SRAM_WR     = HOST_WR;
    SRAM_WR_DAT = HOST_WR_DAT;
    SRAM_BYTEEN = HOST_BYTEEN;
    host_wait_s = 1'b0;
    if (state_r == ST_IDLE) begin
      host_wait_s = 1'b0;
    end else begin
      SRAM_ADDR   = BS_SRAM_ADDR;
      SRAM_CS     = BS_SRAM_CS;
      SRAM_CLKEN  = BS_SRAM_CLKEN;
      SRAM_WR     = BS_SRAM_WR;
      SRAM_WR_DAT = BS_SRAM_WR_DAT;
      SRAM_BYTEEN = BS_SRAM_BYTEEN;
      host_wait_s = host_req_s;
    end
  end

  assign HOST_WAIT      = host_wait_s;
  assign HOST_RD_DAT    = SRAM_RD_DAT;
  assign BS_SRAM_RD_DAT = SRAM_RD_DAT;

  // Sequencer next state and one-cycle status events
  always_comb begin
    next_state_s = state_r;
    scan_done_s  = 1'b0;
    all_done_s   = 1'b0;
    aborted_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (GO) begin
          if (N_SCAN == SCAN_ZERO) begin
            all_done_s = 1'b1;
          end else begin
            next_state_s = ST_STRT;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_STRT: next_state_s = ST_RUN;
      ST_RUN: begin
        if (done_edge_s) begin
          scan_done_s = 1'b1;
          if (scan_cnt_inc_s == n_scan_r) begin
            all_done_s   = 1'b1;
            next_state_s = ST_IDLE;
          end else if (abort_r | ABORT) begin
            // an abort requested during this scan takes effect once it finishes
            aborted_s    = 1'b1;
            next_state_s = ST_IDLE;
          end else if (tr_dly_r == TR_ZERO) begin
            next_state_s = ST_STRT;
          end else begin
            next_state_s = ST_GAP;
          end
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_GAP: begin
        if (ABORT) begin
          aborted_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else if (gap_cnt_r == TR_ZERO) begin
          next_state_s = ST_STRT;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register and DONE edge history
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r        <= ST_IDLE;
      bs_done_prev_r <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      bs_done_prev_r <= BS_DONE;
    end
  end

  // Sequence parameters, scan counter, gap counter and abort flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      n_scan_r   <= SCAN_ZERO;
      tr_dly_r   <= TR_ZERO;
      scan_cnt_r <= SCAN_ZERO;
      gap_cnt_r  <= TR_ZERO;
      abort_r    <= 1'b0;
    end else begin
      if (state_r == ST_IDLE && GO) begin
        n_scan_r   <= N_SCAN;
        tr_dly_r   <= TR_DLY;
        scan_cnt_r <= SCAN_ZERO;
      end else if (scan_done_s) begin
        scan_cnt_r <= scan_cnt_inc_s;
      end
      // GAP lasts TR_DLY cycles, so the counter starts at TR_DLY-1
      if (state_r == ST_RUN && next_state_s == ST_GAP) begin
        gap_cnt_r <= tr_dly_r - TR_ONE;
      end else if (state_r == ST_GAP && gap_cnt_r != TR_ZERO) begin
        gap_cnt_r <= gap_cnt_r - TR_ONE;
      end
      if (next_state_s == ST_IDLE) begin
        abort_r <= 1'b0;
      end else if ((state_r == ST_STRT || state_r == ST_RUN) && ABORT) begin
        abort_r <= 1'b1;
      end
    end
  end

  // Registered status outputs, aligned with the state they describe
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_r      <= 1'b0;
      bs_start_r  <= 1'b0;
      scan_done_r <= 1'b0;
      all_done_r  <= 1'b0;
      aborted_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      busy_r      <= (next_state_s != ST_IDLE);
      bs_start_r  <= (next_state_s == ST_STRT);
      scan_done_r <= scan_done_s;
      all_done_r  <= all_done_s;
      aborted_r   <= aborted_s;
      // a simultaneous write takes the cycle, so no read data follows
      rd_valid_r  <= HOST_RD & ~HOST_WR & ~host_wait_s;
    end
  end

  assign BUSY          = busy_r;
  assign BS_START      = bs_start_r;
  assign SCAN_DONE     = scan_done_r;
  assign ALL_DONE      = all_done_r;
  assign ABORTED       = aborted_r;
  assign HOST_RD_VALID = rd_valid_r;
  assign SCAN_CNT      = scan_cnt_r;

endmodule

// File: tb/tb_nmr_scan_sched.sv
// Directed self-checking bench for nmr_scan_sched with a behavioural SRAM.
module tb_nmr_scan_sched;

  logic         CLK = 1'b0;
  logic         RST;
  logic [7:0]   HOST_ADDR;
  logic         HOST_WR, HOST_RD;
  logic [127:0] HOST_WR_DAT;
  logic [15:0]  HOST_BYTEEN;
  logic         HOST_WAIT;
  logic [127:0] HOST_RD_DAT;
  logic         HOST_RD_VALID;
  logic         GO, ABORT;
  logic [15:0]  N_SCAN;
  logic [31:0]  TR_DLY;
  logic         BUSY;
  logic [15:0]  SCAN_CNT;
  logic         SCAN_DONE, ALL_DONE, ABORTED, BS_START, BS_DONE;
  logic [7:0]   BS_SRAM_ADDR;
  logic         BS_SRAM_CS, BS_SRAM_CLKEN, BS_SRAM_WR;
  logic [127:0] BS_SRAM_WR_DAT;
  logic [15:0]  BS_SRAM_BYTEEN;
  logic [127:0] BS_SRAM_RD_DAT;
  logic [7:0]   SRAM_ADDR;
  logic         SRAM_CS, SRAM_CLKEN, SRAM_WR;
  logic [127:0] SRAM_WR_DAT;
  logic [15:0]  SRAM_BYTEEN;
  logic [127:0] SRAM_RD_DAT;

  int n_assert = 0;
  int n_fail   = 0;
  int start_cnt = 0, all_done_cnt = 0, aborted_cnt = 0;
  int n, start_snap;

  localparam logic [127:0] WORD0 = 128'h0000_0000_0000_0005_0005_0005_0003_0000;
  localparam logic [127:0] WORD1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;

  nmr_scan_sched dut (
    .CLK(CLK), .RST(RST),
    .HOST_ADDR(HOST_ADDR), .HOST_WR(HOST_WR), .HOST_RD(HOST_RD),
    .HOST_WR_DAT(HOST_WR_DAT), .HOST_BYTEEN(HOST_BYTEEN), .HOST_WAIT(HOST_WAIT),
    .HOST_RD_DAT(HOST_RD_DAT), .HOST_RD_VALID(HOST_RD_VALID),
    .GO(GO), .ABORT(ABORT), .N_SCAN(N_SCAN), .TR_DLY(TR_DLY),
    .BUSY(BUSY), .SCAN_CNT(SCAN_CNT), .SCAN_DONE(SCAN_DONE), .ALL_DONE(ALL_DONE),
    .ABORTED(ABORTED), .BS_START(BS_START), .BS_DONE(BS_DONE),
    .BS_SRAM_ADDR(BS_SRAM_ADDR), .BS_SRAM_CS(BS_SRAM_CS), .BS_SRAM_CLKEN(BS_SRAM_CLKEN),
    .BS_SRAM_WR(BS_SRAM_WR), .BS_SRAM_WR_DAT(BS_SRAM_WR_DAT), .BS_SRAM_BYTEEN(BS_SRAM_BYTEEN),
    .BS_SRAM_RD_DAT(BS_SRAM_RD_DAT),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CS(SRAM_CS), .SRAM_CLKEN(SRAM_CLKEN), .SRAM_WR(SRAM_WR),
    .SRAM_WR_DAT(SRAM_WR_DAT), .SRAM_BYTEEN(SRAM_BYTEEN), .SRAM_RD_DAT(SRAM_RD_DAT)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port SRAM, one-cycle read latency
  logic [127:0] mem [256];
  logic [127:0] rd_q = 128'h0;
  assign SRAM_RD_DAT = rd_q;
  always @(posedge CLK) begin
    if (SRAM_CS && SRAM_CLKEN) begin
      if (SRAM_WR) begin
        for (int b = 0; b < 16; b++)
          if (SRAM_BYTEEN[b]) mem[SRAM_ADDR][b*8 +: 8] <= SRAM_WR_DAT[b*8 +: 8];
      end else begin
        rd_q <= mem[SRAM_ADDR];
      end
    end
  end

  // Pulse counters sampled on the falling edge
  always @(negedge CLK) begin
    if (RST) begin
      if (BS_START) start_cnt++;
      if (ALL_DONE) all_done_cnt++;
      if (ABORTED)  aborted_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b0; HOST_ADDR = 8'h00; HOST_WR = 1'b0; HOST_RD = 1'b0;
    HOST_WR_DAT = 128'h0; HOST_BYTEEN = 16'hFFFF; GO = 1'b0; ABORT = 1'b0;
    N_SCAN = 16'd0; TR_DLY = 32'd0; BS_DONE = 1'b0;
    BS_SRAM_ADDR = 8'h00; BS_SRAM_CS = 1'b0; BS_SRAM_CLKEN = 1'b0; BS_SRAM_WR = 1'b0;
    BS_SRAM_WR_DAT = 128'h0; BS_SRAM_BYTEEN = 16'h0000;
    #12;
    // reset state
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_scan_cnt", SCAN_CNT, 16'd0);
    chk("rst_start", BS_START, 1'b0);
    chk("rst_rd_valid", HOST_RD_VALID, 1'b0);
    @(negedge CLK); RST = 1'b1;
    tick;

    // host write of word 0, then read back
    HOST_ADDR = 8'h00; HOST_WR = 1'b1; HOST_WR_DAT = WORD0;
    #1;
    chk("wr_wait", HOST_WAIT, 1'b0);
    chk("wr_cs", SRAM_CS, 1'b1);
    chk("wr_we", SRAM_WR, 1'b1);
    chk("wr_dat", SRAM_WR_DAT, WORD0);
    tick;
    HOST_WR = 1'b0; HOST_RD = 1'b1;
    #1;
    chk("rd_wait", HOST_WAIT, 1'b0);
    chk("rd_we", SRAM_WR, 1'b0);
    tick;
    HOST_RD = 1'b0;
    chk("rd_valid", HOST_RD_VALID, 1'b1);
    chk("rd_dat", HOST_RD_DAT, WORD0);
    tick;
    chk("rd_valid_drop", HOST_RD_VALID, 1'b0);
    // write and read together: write wins, no read-valid
    HOST_ADDR = 8'h01; HOST_WR = 1'b1; HOST_RD = 1'b1; HOST_WR_DAT = WORD1;
    tick;
    HOST_WR = 1'b0; HOST_RD = 1'b0;
    chk("wr_rd_no_valid", HOST_RD_VALID, 1'b0);

    // N_SCAN=3, TR_DLY=4, DONE 20 cycles after each START
    N_SCAN = 16'd3; TR_DLY = 32'd4; GO = 1'b1;
    tick;
    GO = 1'b0;
    chk("t2_cnt_clr", SCAN_CNT, 16'd0);
    for (int k = 1; k <= 3; k++) begin
      chk("t2_start_hi", BS_START, 1'b1);
      chk("t2_busy", BUSY, 1'b1);
      tick;
      chk("t2_start_lo", BS_START, 1'b0);
      if (k == 1) begin
        HOST_ADDR = 8'h10; HOST_WR = 1'b1; HOST_WR_DAT = WORD1;
        BS_SRAM_ADDR = 8'h55; BS_SRAM_CS = 1'b1; BS_SRAM_CLKEN = 1'b1; BS_SRAM_WR = 1'b0;
        BS_SRAM_WR_DAT = 128'h1234; BS_SRAM_BYTEEN = 16'h00F0;
        #1;
        chk("run_wait", HOST_WAIT, 1'b1);
        chk("run_addr", SRAM_ADDR, 8'h55);
        chk("run_we", SRAM_WR, 1'b0);
        chk("run_wdat", SRAM_WR_DAT, 128'h1234);
        chk("run_byteen", SRAM_BYTEEN, 16'h00F0);
        tick;
        chk("run_no_valid", HOST_RD_VALID, 1'b0);
        chk("run_rd_dat", BS_SRAM_RD_DAT, SRAM_RD_DAT);
        HOST_WR = 1'b0; BS_SRAM_CS = 1'b0; BS_SRAM_CLKEN = 1'b0;
        repeat (17) tick;
      end else begin
        repeat (18) tick;
      end
      BS_DONE = 1'b1;
      tick;
      BS_DONE = 1'b0;
      chk("t2_scan_cnt", SCAN_CNT, k[15:0]);
      chk("t2_scan_done", SCAN_DONE, 1'b1);
      if (k < 3) begin
        chk("t2_no_all_done", ALL_DONE, 1'b0);
        // DONE high in cycle c; START must be high in cycle c+5 (TR_DLY+1),
        // i.e. four ticks after the tick that sampled DONE
        n = 0;
        while (!BS_START && n < 50) begin
          tick;
          n++;
        end
        chk("t2_gap_len", n, 4);
      end else begin
        chk("t2_all_done", ALL_DONE, 1'b1);
        chk("t2_busy_low", BUSY, 1'b0);
        tick;
        chk("t2_all_done_1cyc", ALL_DONE, 1'b0);
        chk("t2_scan_done_1cyc", SCAN_DONE, 1'b0);
        chk("t2_cnt_hold", SCAN_CNT, 16'd3);
      end
    end
    chk("t2_start_count", start_cnt, 3);
    chk("t2_all_done_count", all_done_cnt, 1);

    // same host write now accepted, then read back
    HOST_ADDR = 8'h10; HOST_WR = 1'b1; HOST_WR_DAT = WORD1;
    #1;
    chk("post_wait", HOST_WAIT, 1'b0);
    chk("post_addr", SRAM_ADDR, 8'h10);
    tick;
    HOST_WR = 1'b0; HOST_RD = 1'b1;
    tick;
    HOST_RD = 1'b0;
    chk("post_rd_valid", HOST_RD_VALID, 1'b1);
    chk("post_rd_dat", HOST_RD_DAT, WORD1);

    // N_SCAN=0: ALL_DONE next cycle, no START, BUSY stays low
    N_SCAN = 16'd0; GO = 1'b1;
    tick;
    GO = 1'b0;
    chk("z_all_done", ALL_DONE, 1'b1);
    chk("z_busy", BUSY, 1'b0);
    chk("z_start", BS_START, 1'b0);
    chk("z_cnt_clr", SCAN_CNT, 16'd0);
    tick;
    chk("z_all_done_1cyc", ALL_DONE, 1'b0);
    chk("z_start_count", start_cnt, 3);

    // N_SCAN=5, TR_DLY=2, ABORT during scan 2
    N_SCAN = 16'd5; TR_DLY = 32'd2; GO = 1'b1;
    tick;
    GO = 1'b0;
    chk("a_start1", BS_START, 1'b1);
    repeat (6) tick;
    BS_DONE = 1'b1;
    tick;
    BS_DONE = 1'b0;
    chk("a_cnt1", SCAN_CNT, 16'd1);
    n = 0;
    while (!BS_START && n < 50) begin
      tick;
      n++;
    end
    chk("a_gap_len", n, 2);
    repeat (2) tick;
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    chk("a_still_busy", BUSY, 1'b1);
    chk("a_no_abort_yet", ABORTED, 1'b0);
    repeat (5) tick;
    BS_DONE = 1'b1;
    tick;
    BS_DONE = 1'b0;
    chk("a_cnt2", SCAN_CNT, 16'd2);
    chk("a_scan_done", SCAN_DONE, 1'b1);
    chk("a_aborted", ABORTED, 1'b1);
    chk("a_no_all_done", ALL_DONE, 1'b0);
    chk("a_busy_low", BUSY, 1'b0);
    start_snap = start_cnt;
    tick;
    chk("a_aborted_1cyc", ABORTED, 1'b0);
    repeat (6) tick;
    chk("a_no_restart", start_cnt, start_snap);
    chk("a_all_done_count", all_done_cnt, 2);

    // ABORT in GAP: IDLE next cycle
    N_SCAN = 16'd5; TR_DLY = 32'd10; GO = 1'b1;
    tick;
    GO = 1'b0;
    chk("g_start", BS_START, 1'b1);
    repeat (4) tick;
    BS_DONE = 1'b1;
    tick;
    BS_DONE = 1'b0;
    chk("g_busy", BUSY, 1'b1);
    chk("g_cnt", SCAN_CNT, 16'd1);
    tick;
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    chk("g_aborted", ABORTED, 1'b1);
    chk("g_busy_low", BUSY, 1'b0);
    tick;
    chk("g_aborted_1cyc", ABORTED, 1'b0);
    chk("g_no_start", BS_START, 1'b0);
    chk("g_aborted_count", aborted_cnt, 2);

    // reset mid-RUN
    N_SCAN = 16'd2; TR_DLY = 32'd0; GO = 1'b1;
    tick;
    GO = 1'b0;
    repeat (2) tick;
    BS_SRAM_ADDR = 8'h77; BS_SRAM_CS = 1'b1; HOST_ADDR = 8'h22; HOST_RD = 1'b1;
    #1;
    chk("r_bs_owns", SRAM_ADDR, 8'h77);
    chk("r_wait", HOST_WAIT, 1'b1);
    BS_DONE = 1'b1;
    #2 RST = 1'b0;
    #1;
    chk("r_busy", BUSY, 1'b0);
    chk("r_cnt", SCAN_CNT, 16'd0);
    chk("r_start", BS_START, 1'b0);
    chk("r_host_owns", SRAM_ADDR, 8'h22);
    chk("r_host_wait", HOST_WAIT, 1'b0);
    chk("r_rd_valid", HOST_RD_VALID, 1'b0);
    HOST_RD = 1'b0; BS_SRAM_CS = 1'b0;
    @(negedge CLK); RST = 1'b1;
    repeat (2) tick;
    chk("r_stale_done", SCAN_DONE, 1'b0);
    chk("r_stale_cnt", SCAN_CNT, 16'd0);
    chk("r_stale_busy", BUSY, 1'b0);
    BS_DONE = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nmr_scan_sched.md
Name: nmr_scan_sched

Overview:
- Scan scheduler and SRAM port arbiter that sits in front of the NMR bitstream generator (NMR_bstrm) and its single-port on-chip command SRAM.
- While idle, the host owns the SRAM so it can load 128-bit command words (delays, pulse width, loop count, command bits).
- On GO, the block hands the SRAM to the bitstream generator and sequences N_SCAN repetitions: START pulse, wait DONE, repetition delay TR_DLY.
- Provides scan progress, completion and abort status to the host.

Parameters:
- SRAM_ADDR_WIDTH, 8, SRAM address width
- SRAM_DAT_WIDTH, 128, SRAM data width
- SRAM_BYTEEN_WIDTH, 16, SRAM byte-enable width
- SCAN_WIDTH, 16, scan counter width
- TR_WIDTH, 32, repetition-delay counter width (clock cycles)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- HOST_ADDR  in  SRAM_ADDR_WIDTH  host SRAM address
- HOST_WR  in  1  host write request
- HOST_RD  in  1  host read request
- HOST_WR_DAT  in  SRAM_DAT_WIDTH  host write data
- HOST_BYTEEN  in  SRAM_BYTEEN_WIDTH  host byte enable
- HOST_WAIT  out  1  host wait-request: access not accepted this cycle
- HOST_RD_DAT  out  SRAM_DAT_WIDTH  host read data
- HOST_RD_VALID  out  1  HOST_RD_DAT valid
- GO  in  1  start scan sequence (level; sampled in IDLE only)
- ABORT  in  1  abort request
- N_SCAN  in  SCAN_WIDTH  number of scans
- TR_DLY  in  TR_WIDTH  cycles between DONE and next START
- BUSY  out  1  sequence active
- SCAN_CNT  out  SCAN_WIDTH  completed scans
- SCAN_DONE  out  1  one-cycle pulse per completed scan
- ALL_DONE  out  1  one-cycle pulse when sequence completes normally
- ABORTED  out  1  one-cycle pulse when sequence ends by abort
- BS_START  out  1  START to NMR_bstrm
- BS_DONE  in  1  DONE from NMR_bstrm
- BS_SRAM_ADDR, BS_SRAM_CS, BS_SRAM_CLKEN, BS_SRAM_WR, BS_SRAM_WR_DAT, BS_SRAM_BYTEEN  in  (SRAM widths)  generator SRAM request
- BS_SRAM_RD_DAT  out  SRAM_DAT_WIDTH  generator read data
- SRAM_ADDR, SRAM_CS, SRAM_CLKEN, SRAM_WR, SRAM_WR_DAT, SRAM_BYTEEN  out  (SRAM widths)  physical SRAM port
- SRAM_RD_DAT  in  SRAM_DAT_WIDTH  physical SRAM read data

Behaviour:
- Reset (RST=0, async):
  - State IDLE.
  - All registered outputs 0: BUSY, SCAN_CNT, pulses, BS_START, HOST_RD_VALID.
  - Counters cleared; abort flag cleared.
- States: IDLE, STRT, RUN, GAP.
- SRAM mux, combinational on state:
  - IDLE: host drives the SRAM with CS=CLKEN=(HOST_WR|HOST_RD), WR=HOST_WR, and HOST_WAIT=0.
  - Non-IDLE: BS_SRAM_* drive the SRAM, and HOST_WAIT=(HOST_WR|HOST_RD).
- BS_SRAM_RD_DAT = SRAM_RD_DAT always. HOST_RD_DAT = SRAM_RD_DAT.
- HOST_RD_VALID is HOST_RD&~HOST_WAIT, registered: 1-cycle read latency.
- HOST_WR and HOST_RD together: write wins, no read-valid.
- IDLE, GO=1:
  - Latch N_SCAN and TR_DLY; clear SCAN_CNT.
  - If latched N_SCAN=0: stay IDLE and pulse ALL_DONE next cycle.
  - Otherwise: go to STRT with BUSY=1.
  - A host access in the GO cycle is still serviced.
- STRT: BS_START=1 for exactly one cycle, then RUN.
- RUN: waits for a rising edge of BS_DONE (BS_DONE registered; edge = BS_DONE & ~prev).
  - On edge: SCAN_CNT+1 and SCAN_DONE pulse.
  - If new count = N_SCAN: ALL_DONE pulse, go to IDLE.
  - Else if abort flag is set: ABORTED pulse, go to IDLE.
  - Else if TR_DLY=0: go to STRT.
  - Else: load the gap counter and go to GAP.
- GAP: counts TR_DLY cycles, then STRT.
  - DONE-edge to next BS_START = TR_DLY+1 cycles.
- ABORT:
  - In STRT/RUN: set the abort flag; the current scan always finishes, because NMR_bstrm has no abort.
  - In GAP: go to IDLE next cycle with an ABORTED pulse.
  - In IDLE: ignored.
  - Abort flag is cleared on entering IDLE.
- BUSY=1 in all states other than IDLE; it drops in the same cycle as the ALL_DONE/ABORTED pulse.
- BS_DONE edges outside RUN are ignored. GO outside IDLE is ignored.
- SCAN_CNT holds its final value until the next accepted GO.
- Any mid-sequence reset returns to IDLE immediately and gives SRAM ownership back to the host.

Test Plan:
- Host writes word 0x..._0005_0005_0005_0003_0000 to addr 0, then reads it back → HOST_WAIT=0 throughout; HOST_RD_VALID 1 cycle after RD with matching data.
- GO, N_SCAN=3, TR_DLY=4, model DONE 20 cycles after each START → 3 one-cycle BS_START pulses, each 5 cycles after a DONE edge; SCAN_CNT 1,2,3; single ALL_DONE; BUSY low afterwards.
- During RUN, host write → HOST_WAIT=1 and SRAM_ADDR follows BS_SRAM_ADDR; after ALL_DONE the same write is accepted.
- GO with N_SCAN=0 → no BS_START; ALL_DONE pulse next cycle; BUSY stays 0.
- N_SCAN=5, ABORT during scan 2 RUN → scan 2 completes (SCAN_CNT=2), ABORTED pulse, no ALL_DONE; separately ABORT in GAP → IDLE next cycle.
- RST asserted low mid-RUN → all outputs 0 asynchronously, SRAM mux returns to host, stale BS_DONE ignored.
